// File: rtl/fpu_ctrl_pkg.sv
// fpu_ctrl_pkg: opcode, response-error and FSM state types plus opcode classifiers
package fpu_ctrl_pkg;

    typedef enum logic [3:0] {
        OPC_FCLASS = 4'd0,
        OPC_SGNINJ = 4'd1,
        OPC_CMP    = 4'd2,
        OPC_MINMAX = 4'd3,
        OPC_I2F    = 4'd4,
        OPC_F2I    = 4'd5,
        OPC_ADDSUB = 4'd6,
        OPC_MUL    = 4'd7,
        OPC_FMA    = 4'd8,
        OPC_DIV    = 4'd9,
        OPC_SQRT   = 4'd10
    } opc_e;

    typedef enum logic [1:0] {
        ERR_OK      = 2'b00,
        ERR_ILLEGAL = 2'b01,
        ERR_TIMEOUT = 2'b10
    } resp_err_e;

    typedef enum logic [1:0] {IDLE, EXEC, WAIT, RESP} state_e;

    function automatic logic is_multicycle(input logic [3:0] opc);
        return opc == OPC_DIV || opc == OPC_SQRT;
    endfunction

    // sgninj and cmp only define sub-ops 0..2
    function automatic logic is_illegal(input logic [3:0] opc, input logic [1:0] op);
        return opc > 4'd10 || ((opc == OPC_SGNINJ || opc == OPC_CMP) && op == 2'b11);
    endfunction

endpackage

// File: rtl/fpu_cmd_fifo.sv
// fpu_cmd_fifo: registered command queue, no bypass, flush empties it in one cycle
module fpu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         flush_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q;
    logic          do_push, do_pop;

    assign full_o  = cnt_q == (AW+1)'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;
    assign dout_o  = mem_q[rd_q];

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop) rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din_i;
    end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: queues tagged FPU commands, issues them one-hot, waits on div/sqrt,
// returns tagged responses and keeps sticky IEEE flags.
module fpu_issue_ctrl
    import fpu_ctrl_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_opc,
    input  logic [1:0]       cmd_op,
    input  logic [2:0]       cmd_rm,
    input  logic [31:0]      cmd_a,
    input  logic [31:0]      cmd_b,
    input  logic [31:0]      cmd_c,
    input  logic [TAG_W-1:0] cmd_tag,
    input  logic             flush,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_data,
    output logic [4:0]       resp_exc,
    output logic [TAG_W-1:0] resp_tag,
    output logic [1:0]       resp_err,
    output logic [4:0]       fflags,
    input  logic             fflags_clr,
    output logic             busy,
    output logic [10:0]      fpu_valid,
    output logic [1:0]       fpu_op,
    output logic [2:0]       fpu_rm,
    output logic [31:0]      fpu_a,
    output logic [31:0]      fpu_b,
    output logic [31:0]      fpu_c,
    output logic             fpu_cancel,
    input  logic [31:0]      fpu_result,
    input  logic [4:0]       fpu_exc,
    input  logic             fpu_div_done,
    input  logic             fpu_sqrt_done
);
    localparam int CW = 4 + 2 + 3 + 96 + TAG_W;
    localparam int TW = $clog2(TIMEOUT);

    state_e          state_q, state_d;
    logic [CW-1:0]   cmd_q, cmd_d, fifo_dout;
    logic [31:0]     data_q, data_d;
    logic [4:0]      exc_q, exc_d, fflags_q, fflags_d;
    resp_err_e       err_q, err_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [3:0]      opc;
    logic            pop, fifo_full, fifo_empty, own_done, accept;

    fpu_cmd_fifo #(.DEPTH(DEPTH), .W(CW)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (cmd_valid),
        .pop_i   (pop),
        .flush_i (flush),
        .din_i   ({cmd_opc, cmd_op, cmd_rm, cmd_a, cmd_b, cmd_c, cmd_tag}),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign {opc, fpu_op, fpu_rm, fpu_a, fpu_b, fpu_c, resp_tag} = cmd_q;
    assign cmd_ready  = !fifo_full;
    assign resp_valid = state_q == RESP;
    assign resp_data  = data_q;
    assign resp_exc   = exc_q;
    assign resp_err   = err_q;
    assign fflags     = fflags_q;
    assign busy       = state_q != IDLE || !fifo_empty;
    assign fpu_valid  = state_q == EXEC ? 11'(1) << opc : '0;
    assign fpu_cancel = flush && state_q == WAIT;
    assign own_done   = opc == OPC_DIV ? fpu_div_done : fpu_sqrt_done;
    assign accept     = resp_valid && resp_ready && !flush;

    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        data_d   = data_q;
        exc_d    = exc_q;
        err_d    = err_q;
        timer_d  = timer_q;
        pop      = 1'b0;
        fflags_d = (fflags_clr ? 5'b0 : fflags_q) | (accept && err_q == ERR_OK ? exc_q : 5'b0);
        unique case (state_q)
            IDLE: if (!fifo_empty) begin
                pop   = 1'b1;
                cmd_d = fifo_dout;
                if (is_illegal(fifo_dout[CW-1 -: 4], fifo_dout[CW-5 -: 2])) begin
                    state_d = RESP;
                    data_d  = '0;
                    exc_d   = '0;
                    err_d   = ERR_ILLEGAL;
                end else begin
                    state_d = EXEC;
                end
            end
            EXEC: if (is_multicycle(opc)) begin
                timer_d = '0;
                state_d = WAIT;
            end else begin
                data_d  = fpu_result;
                exc_d   = fpu_exc;
                err_d   = ERR_OK;
                state_d = RESP;
            end
            WAIT: if (own_done) begin
                data_d  = fpu_result;
                exc_d   = fpu_exc;
                err_d   = ERR_OK;
                state_d = RESP;
            end else if (timer_q == TW'(TIMEOUT - 1)) begin
                data_d  = '0;
                exc_d   = '0;
                err_d   = ERR_TIMEOUT;
                state_d = RESP;
            end else begin
                timer_d = timer_q + 1'b1;
            end
            RESP: if (resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cmd_q    <= '0;
            data_q   <= '0;
            exc_q    <= '0;
            err_q    <= ERR_OK;
            timer_q  <= '0;
            fflags_q <= '0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            data_q   <= data_d;
            exc_q    <= exc_d;
            err_q    <= err_d;
            timer_q  <= timer_d;
            fflags_q <= fflags_d;
        end
    end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// tb_fpu_issue_ctrl: directed scenario tasks for fpu_issue_ctrl with a stub datapath
module tb_fpu_issue_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready;
    logic [3:0]  cmd_opc;
    logic [1:0]  cmd_op;
    logic [2:0]  cmd_rm;
    logic [31:0] cmd_a, cmd_b, cmd_c;
    logic [3:0]  cmd_tag;
    logic        flush;
    logic        resp_valid, resp_ready;
    logic [31:0] resp_data;
    logic [4:0]  resp_exc;
    logic [3:0]  resp_tag;
    logic [1:0]  resp_err;
    logic [4:0]  fflags;
    logic        fflags_clr, busy;
    logic [10:0] fpu_valid;
    logic [1:0]  fpu_op;
    logic [2:0]  fpu_rm;
    logic [31:0] fpu_a, fpu_b, fpu_c;
    logic        fpu_cancel;
    logic [31:0] fpu_result;
    logic [4:0]  fpu_exc;
    logic        fpu_div_done, fpu_sqrt_done;

    logic        use_a;
    logic [31:0] stub_res;
    logic [4:0]  stub_exc;
    int          checks = 0;
    int          errors = 0;

    assign fpu_result = use_a ? fpu_a : stub_res;
    assign fpu_exc    = stub_exc;

    always #5 clk = ~clk;

    fpu_issue_ctrl #(.DEPTH(4), .TAG_W(4), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opc(cmd_opc), .cmd_op(cmd_op),
        .cmd_rm(cmd_rm), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_c(cmd_c), .cmd_tag(cmd_tag),
        .flush(flush), .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_exc(resp_exc), .resp_tag(resp_tag), .resp_err(resp_err), .fflags(fflags),
        .fflags_clr(fflags_clr), .busy(busy), .fpu_valid(fpu_valid), .fpu_op(fpu_op),
        .fpu_rm(fpu_rm), .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_c(fpu_c), .fpu_cancel(fpu_cancel),
        .fpu_result(fpu_result), .fpu_exc(fpu_exc), .fpu_div_done(fpu_div_done),
        .fpu_sqrt_done(fpu_sqrt_done)
    );

    // called at a negedge; the command is offered across the next posedge
    task automatic push(input logic [3:0] opc, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [3:0] tag);
        cmd_valid = 1'b1; cmd_opc = opc; cmd_op = op; cmd_rm = 3'd1;
        cmd_a = a; cmd_b = b; cmd_c = 32'h0; cmd_tag = tag;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || resp_valid !== 1'b0 || busy !== 1'b0 || fpu_valid !== 11'h0 ||
            fflags !== 5'h0 || fpu_cancel !== 1'b0 || resp_data !== 32'h0 || fpu_a !== 32'h0) begin
            $display("FAIL reset: ready=%b rvalid=%b busy=%b fvalid=%h fflags=%h cancel=%b data=%h a=%h, want 1 0 0 0 0 0 0 0",
                     cmd_ready, resp_valid, busy, fpu_valid, fflags, fpu_cancel, resp_data, fpu_a);
            errors++;
        end
        rst = 1'b0;
    endtask

    task automatic test_mul();
        use_a = 1'b0; stub_res = 32'h40C00000; stub_exc = 5'b0; resp_ready = 1'b1;
        push(4'd7, 2'd0, 32'h40000000, 32'h40400000, 4'd3);
        checks++;
        if (resp_valid !== 1'b0 || busy !== 1'b1) begin
            $display("FAIL mul_t1: rvalid=%b busy=%b, want 0 1", resp_valid, busy); errors++;
        end
        @(negedge clk);
        checks++;
        if (fpu_valid !== 11'h080 || fpu_a !== 32'h40000000 || fpu_b !== 32'h40400000 || fpu_rm !== 3'd1) begin
            $display("FAIL mul_issue: fvalid=%h a=%h b=%h rm=%0d, want 080 40000000 40400000 1",
                     fpu_valid, fpu_a, fpu_b, fpu_rm); errors++;
        end
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b1 || resp_data !== 32'h40C00000 || resp_tag !== 4'd3 ||
            resp_err !== 2'b00 || resp_exc !== 5'b0 || fpu_valid !== 11'h0) begin
            $display("FAIL mul_resp: rvalid=%b data=%h tag=%0d err=%b exc=%b fvalid=%h, want 1 40c00000 3 00 00000 000",
                     resp_valid, resp_data, resp_tag, resp_err, resp_exc, fpu_valid); errors++;
        end
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL mul_done: rvalid=%b busy=%b, want 0 0", resp_valid, busy); errors++;
        end
    endtask

    task automatic test_div();
        use_a = 1'b0; stub_res = 32'h3EAAAAAB; stub_exc = 5'b01000; resp_ready = 1'b1;
        push(4'd9, 2'd0, 32'h3F800000, 32'h40400000, 4'd5);
        @(negedge clk);
        checks++;
        if (fpu_valid !== 11'h200) begin
            $display("FAIL div_issue: fvalid=%h, want 200", fpu_valid); errors++;
        end
        fpu_sqrt_done = 1'b1;
        repeat (20) @(negedge clk);
        checks++;
        if (resp_valid !== 1'b0 || fpu_valid !== 11'h0 || fpu_a !== 32'h3F800000 || busy !== 1'b1) begin
            $display("FAIL div_wait: rvalid=%b fvalid=%h a=%h busy=%b, want 0 000 3f800000 1",
                     resp_valid, fpu_valid, fpu_a, busy); errors++;
        end
        fpu_sqrt_done = 1'b0; fpu_div_done = 1'b1;
        @(negedge clk);
        fpu_div_done = 1'b0;
        checks++;
        if (resp_valid !== 1'b1 || resp_data !== 32'h3EAAAAAB || resp_exc !== 5'b01000 ||
            resp_tag !== 4'd5 || resp_err !== 2'b00 || fflags !== 5'b0) begin
            $display("FAIL div_resp: rvalid=%b data=%h exc=%b tag=%0d err=%b fflags=%b, want 1 3eaaaaab 01000 5 00 00000",
                     resp_valid, resp_data, resp_exc, resp_tag, resp_err, fflags); errors++;
        end
        @(negedge clk);
        checks++;
        if (fflags !== 5'b01000 || resp_valid !== 1'b0) begin
            $display("FAIL div_fflags: fflags=%b rvalid=%b, want 01000 0", fflags, resp_valid); errors++;
        end
        fflags_clr = 1'b1;
        @(negedge clk);
        fflags_clr = 1'b0;
        checks++;
        if (fflags !== 5'b0) begin
            $display("FAIL fflags_clr: fflags=%b, want 00000", fflags); errors++;
        end
    endtask

    task automatic test_illegal();
        logic [3:0] exp_tag [2];
        int got = 0;
        logic issued = 1'b0;
        exp_tag[0] = 4'd6; exp_tag[1] = 4'd7;
        use_a = 1'b0; stub_res = 32'h12345678; stub_exc = 5'b10101; resp_ready = 1'b0;
        push(4'd2, 2'b11, 32'h1, 32'h2, 4'd6);
        push(4'd12, 2'b00, 32'h3, 32'h4, 4'd7);
        resp_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (fpu_valid !== 11'h0) issued = 1'b1;
            if (resp_valid === 1'b1) begin
                checks++;
                if (got > 1 || resp_err !== 2'b01 || resp_data !== 32'h0 || resp_exc !== 5'b0 ||
                    resp_tag !== exp_tag[got[0]]) begin
                    $display("FAIL illegal_resp%0d: err=%b data=%h exc=%b tag=%0d, want 01 0 0 %0d",
                             got, resp_err, resp_data, resp_exc, resp_tag, exp_tag[got[0]]); errors++;
                end
                got++;
            end
            @(negedge clk);
        end
        checks++;
        if (got != 2 || issued !== 1'b0 || busy !== 1'b0 || fflags !== 5'b0) begin
            $display("FAIL illegal_count: responses=%0d issued=%b busy=%b fflags=%b, want 2 0 0 00000",
                     got, issued, busy, fflags); errors++;
        end
    endtask

    task automatic test_timeout();
        logic early = 1'b0;
        use_a = 1'b0; stub_res = 32'hDEADBEEF; stub_exc = 5'b11111; resp_ready = 1'b1;
        push(4'd10, 2'd0, 32'h40800000, 32'h0, 4'd9);
        @(negedge clk);
        checks++;
        if (fpu_valid !== 11'h400) begin
            $display("FAIL sqrt_issue: fvalid=%h, want 400", fpu_valid); errors++;
        end
        fpu_div_done = 1'b1;
        for (int k = 1; k <= 64; k++) begin
            @(negedge clk);
            if (resp_valid !== 1'b0) early = 1'b1;
        end
        checks++;
        if (early !== 1'b0) begin
            $display("FAIL sqrt_early: early response seen=%b, want 0", early); errors++;
        end
        @(negedge clk);
        fpu_div_done = 1'b0;
        checks++;
        if (resp_valid !== 1'b1 || resp_err !== 2'b10 || resp_data !== 32'h0 ||
            resp_exc !== 5'b0 || resp_tag !== 4'd9) begin
            $display("FAIL sqrt_timeout: rvalid=%b err=%b data=%h exc=%b tag=%0d, want 1 10 0 0 9",
                     resp_valid, resp_err, resp_data, resp_exc, resp_tag); errors++;
        end
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b0 || fflags !== 5'b0 || busy !== 1'b0) begin
            $display("FAIL sqrt_after: rvalid=%b fflags=%b busy=%b, want 0 00000 0",
                     resp_valid, fflags, busy); errors++;
        end
    endtask

    task automatic test_back_to_back();
        int got = 0;
        use_a = 1'b1; stub_exc = 5'b00001; resp_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            checks++;
            if (cmd_ready !== 1'b1) begin
                $display("FAIL b2b_ready%0d: ready=%b, want 1", i, cmd_ready); errors++;
            end
            push(4'd0, 2'd0, 32'h100 + 32'(i), 32'h0, 4'(i));
        end
        checks++;
        if (cmd_ready !== 1'b0 || resp_valid !== 1'b1) begin
            $display("FAIL b2b_full: ready=%b rvalid=%b, want 0 1", cmd_ready, resp_valid); errors++;
        end
        push(4'd0, 2'd0, 32'h106, 32'h0, 4'd6);
        resp_ready = 1'b1;
        for (int c = 0; c < 60 && got < 6; c++) begin
            if (resp_valid === 1'b1) begin
                got++;
                checks++;
                if (resp_tag !== 4'(got) || resp_data !== 32'h100 + 32'(got) || resp_err !== 2'b00) begin
                    $display("FAIL b2b_order%0d: tag=%0d data=%h err=%b, want %0d %h 00",
                             got, resp_tag, resp_data, resp_err, got, 32'h100 + 32'(got)); errors++;
                end
            end
            @(negedge clk);
        end
        checks++;
        if (got != 5 || busy !== 1'b0 || fflags !== 5'b00001) begin
            $display("FAIL b2b_drain: responses=%0d busy=%b fflags=%b, want 5 0 00001", got, busy, fflags); errors++;
        end
    endtask

    task automatic test_flush();
        logic seen = 1'b0;
        use_a = 1'b0; stub_res = 32'h0; stub_exc = 5'b0; resp_ready = 1'b1;
        push(4'd9, 2'd0, 32'h1, 32'h2, 4'd10);
        push(4'd6, 2'd0, 32'h3, 32'h4, 4'd11);
        push(4'd7, 2'd0, 32'h5, 32'h6, 4'd12);
        checks++;
        if (busy !== 1'b1 || fpu_cancel !== 1'b0 || fpu_valid !== 11'h0 || resp_valid !== 1'b0) begin
            $display("FAIL flush_pre: busy=%b cancel=%b fvalid=%h rvalid=%b, want 1 0 000 0",
                     busy, fpu_cancel, fpu_valid, resp_valid); errors++;
        end
        flush = 1'b1;
        #1;
        checks++;
        if (fpu_cancel !== 1'b1) begin
            $display("FAIL flush_cancel: cancel=%b, want 1", fpu_cancel); errors++;
        end
        @(negedge clk);
        flush = 1'b0;
        checks++;
        if (fpu_cancel !== 1'b0 || busy !== 1'b0 || resp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            $display("FAIL flush_post: cancel=%b busy=%b rvalid=%b ready=%b, want 0 0 0 1",
                     fpu_cancel, busy, resp_valid, cmd_ready); errors++;
        end
        fpu_div_done = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (resp_valid !== 1'b0 || fpu_valid !== 11'h0 || busy !== 1'b0) seen = 1'b1;
        end
        fpu_div_done = 1'b0;
        checks++;
        if (seen !== 1'b0) begin
            $display("FAIL flush_quiet: activity after flush=%b, want 0", seen); errors++;
        end
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_opc = '0; cmd_op = '0; cmd_rm = '0;
        cmd_a = '0; cmd_b = '0; cmd_c = '0; cmd_tag = '0; flush = 1'b0; resp_ready = 1'b0;
        fflags_clr = 1'b0; fpu_div_done = 1'b0; fpu_sqrt_done = 1'b0;
        use_a = 1'b0; stub_res = '0; stub_exc = '0;
        test_reset();
        test_mul();
        test_div();
        test_illegal();
        test_timeout();
        test_back_to_back();
        test_flush();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
